// File: rtl/feeder_fifo.sv
// rtl/feeder_fifo.sv - show-ahead word FIFO with last sideband between fetcher and feeder
module feeder_fifo #(
  parameter int DATA_W    = 64,
  parameter int POSITIONS = 8,
  parameter int AFULL_TH  = 6
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic                           i_clear,
  input  logic                           i_push,
  input  logic [DATA_W-1:0]              i_data,
  input  logic                           i_last,
  input  logic                           i_pop,
  input  logic                           i_pipeline_en,
  output logic [DATA_W-1:0]              o_data,
  output logic                           o_last,
  output logic                           o_valid,
  output logic                           o_empty,
  output logic                           o_full,
  output logic                           o_afull,
  output logic [$clog2(POSITIONS+1)-1:0] o_count,
  output logic                           o_overflow,
  output logic                           o_underflow
);

  localparam int PW = (POSITIONS > 1) ? $clog2(POSITIONS) : 1;
  localparam int CW = $clog2(POSITIONS + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(POSITIONS);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_TH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(POSITIONS - 1);

  logic [DATA_W:0] mem [POSITIONS];
  logic [DATA_W:0] head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;
  logic            underflow;
  logic            empty;
  logic            full;
  logic            pop_eff;
  logic            pop_acc;
  logic            push_eff;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop_eff  = i_pop && i_pipeline_en;
  assign pop_acc  = pop_eff && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_eff = i_push && (!full || pop_eff);

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    next_ptr = (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (push_eff && !i_clear) begin
      mem[wr_ptr] <= {i_last, i_data};
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (i_clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_eff) wr_ptr <= next_ptr(wr_ptr);
      if (pop_acc)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_eff, pop_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (i_push && full && !pop_eff) overflow <= 1'b1;
      if (pop_eff && empty) underflow <= 1'b1;
    end
  end

  assign head        = mem[rd_ptr];
  assign o_data      = empty ? '0 : head[DATA_W-1:0];
  assign o_last      = !empty && head[DATA_W];
  assign o_valid     = !empty;
  assign o_empty     = empty;
  assign o_full      = full;
  assign o_afull     = (count >= AFULL_CNT);
  assign o_count     = count;
  assign o_overflow  = overflow;
  assign o_underflow = underflow;

endmodule

// File: tb/tb_feeder_fifo.sv
// tb/tb_feeder_fifo.sv - scoreboard bench for feeder_fifo at 8 and 5 positions
module tb_feeder_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn [2];
  logic        push [2];
  logic        last [2];
  logic        pop  [2];
  logic        pen  [2];
  logic        clr  [2];
  logic [63:0] din  [2];
  logic [63:0] dout [2];
  logic        lout [2];
  logic        valid[2];
  logic        empty[2];
  logic        full [2];
  logic        afull[2];
  logic        ovf  [2];
  logic        udf  [2];
  logic [3:0]  cnt0;
  logic [2:0]  cnt1;

  logic [64:0] sb0[$];
  logic [64:0] sb1[$];
  bit          m_ovf[2];
  bit          m_udf[2];
  int          checks = 0;
  int          passed = 0;

  feeder_fifo #(.DATA_W(64), .POSITIONS(8), .AFULL_TH(6)) u_fifo8 (
    .i_clk(clk), .i_rstn(rstn[0]), .i_clear(clr[0]), .i_push(push[0]),
    .i_data(din[0]), .i_last(last[0]), .i_pop(pop[0]), .i_pipeline_en(pen[0]),
    .o_data(dout[0]), .o_last(lout[0]), .o_valid(valid[0]), .o_empty(empty[0]),
    .o_full(full[0]), .o_afull(afull[0]), .o_count(cnt0),
    .o_overflow(ovf[0]), .o_underflow(udf[0])
  );

  feeder_fifo #(.DATA_W(64), .POSITIONS(5), .AFULL_TH(4)) u_fifo5 (
    .i_clk(clk), .i_rstn(rstn[1]), .i_clear(clr[1]), .i_push(push[1]),
    .i_data(din[1]), .i_last(last[1]), .i_pop(pop[1]), .i_pipeline_en(pen[1]),
    .o_data(dout[1]), .o_last(lout[1]), .o_valid(valid[1]), .o_empty(empty[1]),
    .o_full(full[1]), .o_afull(afull[1]), .o_count(cnt1),
    .o_overflow(ovf[1]), .o_underflow(udf[1])
  );

  // One clock of stimulus on unit u; head/count checked before the edge, flags after.
  task automatic cycle(input int u, input logic p, input logic [63:0] d, input logic l,
                       input logic pp, input logic pe, input logic c);
    int          cap;
    int          th;
    int          n;
    logic [3:0]  cv;
    logic [64:0] exp_head;
    logic        acc;
    logic [5:0]  st_got;
    logic [5:0]  st_exp;
    cap = (u == 0) ? 8 : 5;
    th  = (u == 0) ? 6 : 4;
    n   = (u == 0) ? sb0.size() : sb1.size();
    cv  = (u == 0) ? cnt0 : {1'b0, cnt1};
    push[u] = p; din[u] = d; last[u] = l; pop[u] = pp; pen[u] = pe; clr[u] = c;
    checks++;
    if (cv !== 4'(n)) $display("FAIL count u%0d: got %0d want %0d", u, cv, n);
    else passed++;
    checks++;
    if (n > 0) begin
      exp_head = (u == 0) ? sb0[0] : sb1[0];
      if ({lout[u], dout[u]} !== exp_head)
        $display("FAIL head u%0d: got %h want %h", u, {lout[u], dout[u]}, exp_head);
      else passed++;
    end else begin
      if ({valid[u], lout[u], dout[u]} !== 66'd0)
        $display("FAIL empty_head u%0d: got v=%b d=%h want v=0 d=0", u, valid[u], dout[u]);
      else passed++;
    end
    if (c) begin
      if (u == 0) sb0.delete(); else sb1.delete();
      m_ovf[u] = 0; m_udf[u] = 0;
    end else begin
      acc = p && (n < cap || (pp && pe));
      if (pp && pe) begin
        if (n > 0) begin
          if (u == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
        end else m_udf[u] = 1;
      end
      if (acc) begin
        if (u == 0) sb0.push_back({l, d}); else sb1.push_back({l, d});
      end else if (p) m_ovf[u] = 1;
    end
    @(posedge clk); #1;
    push[u] = 0; pop[u] = 0; pen[u] = 0; clr[u] = 0; last[u] = 0;
    n = (u == 0) ? sb0.size() : sb1.size();
    st_got = {empty[u], full[u], afull[u], ovf[u], udf[u], valid[u]};
    st_exp = {n == 0, n == cap, n >= th, m_ovf[u], m_udf[u], n != 0};
    checks++;
    if (st_got !== st_exp)
      $display("FAIL status u%0d (e,f,af,ov,uf,v): got %b want %b", u, st_got, st_exp);
    else passed++;
  endtask

  task automatic test_reset;
    for (int u = 0; u < 2; u++) begin
      rstn[u] = 0; push[u] = 0; last[u] = 0; pop[u] = 0; pen[u] = 0; clr[u] = 0;
      din[u] = '0;
    end
    #3;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({empty[u], full[u], afull[u], ovf[u], udf[u], valid[u], lout[u]} !== 7'b1000000
          || dout[u] !== 64'd0)
        $display("FAIL reset u%0d: got e=%b f=%b af=%b ov=%b uf=%b v=%b d=%h want 1000000 d=0",
                 u, empty[u], full[u], afull[u], ovf[u], udf[u], valid[u], dout[u]);
      else passed++;
    end
    checks++;
    if (cnt0 !== 4'd0 || cnt1 !== 3'd0) $display("FAIL reset_count: got %0d/%0d want 0/0", cnt0, cnt1);
    else passed++;
    @(negedge clk);
    rstn[0] = 1; rstn[1] = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    cycle(0, 1, 64'hA1, 0, 0, 0, 0);
    cycle(0, 1, 64'hA2, 0, 0, 0, 0);
    cycle(0, 1, 64'hA3, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 1, 0);
  endtask

  task automatic test_fill_overflow;
    for (int i = 0; i < 8; i++) cycle(0, 1, 64'hC0 + 64'(i), i == 7, 0, 0, 0);
    cycle(0, 1, 64'hDD, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 1, 0);
  endtask

  task automatic test_full_push_pop;
    cycle(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(0, 1, 64'h10 + 64'(i), 0, 0, 0, 0);
    cycle(0, 1, 64'hB0, 1, 1, 1, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 1, 0);
  endtask

  task automatic test_underflow;
    cycle(0, 0, 0, 0, 1, 1, 0);
    cycle(0, 1, 64'h55, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 1, 64'h56, 0, 1, 0, 0);
  endtask

  task automatic test_clear;
    for (int i = 0; i < 3; i++) cycle(0, 1, 64'h70 + 64'(i), 0, 0, 0, 0);
    cycle(0, 1, 64'h99, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 20; i++)
      cycle(1, 1, 64'hE0 + 64'(i), (i % 4) == 3, (i % 2) == 1 || i > 12, 1, 0);
    #2;
    rstn[1] = 0;
    #1;
    checks++;
    if (empty[1] !== 1'b1 || cnt1 !== 3'd0 || valid[1] !== 1'b0 || dout[1] !== 64'd0)
      $display("FAIL async_reset: got e=%b cnt=%0d v=%b d=%h want e=1 cnt=0 v=0 d=0",
               empty[1], cnt1, valid[1], dout[1]);
    else passed++;
    sb1.delete(); m_ovf[1] = 0; m_udf[1] = 0;
    #1 rstn[1] = 1;
    for (int i = 0; i < 7; i++) cycle(1, i < 6, 64'hF0 + 64'(i), i == 5, i > 1, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 1, 1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_push_pop();
    test_underflow();
    test_clear();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
